slew_limited_gain_stage: RTL and testbench
==========================================

Name: slew_limited_gain_stage

Overview:
- Parametrised successor to the fixed-gain op-amp gain stage: signed fixed-point input times runtime-programmable gain, saturated to output width, then slew-rate limited to model a finite op-amp slew rate.
- Sits between the differential input stage and the output buffer in the op_amp datapath.
- Streaming valid-qualified samples through a 3-stage pipeline, with saturation reporting and a saturating clip counter.

Parameters:
- DATA_W, 16, input/output sample width (signed two's complement).
- GAIN_W, 16, gain word width (unsigned, fixed point).
- FRAC_BITS, 8, fractional bits in gain word; gain value = gain_in / 2^FRAC_BITS.
- RESET_GAIN, 25600, gain register value after reset (100.0 at FRAC_BITS=8).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input_signal holds a sample this cycle.
- input_signal, in, DATA_W, signed input sample.
- gain_load, in, 1, load gain_in into gain register.
- gain_in, in, GAIN_W, new unsigned gain word.
- slew_rate, in, DATA_W-1, max output change per valid sample (unsigned); 0 = limiter bypassed.
- sat_clr, in, 1, synchronous clear of sat_count.
- out_valid, out, 1, amplified_output holds a new sample.
- amplified_output, out, DATA_W, signed slew-limited output.
- sat_flag, out, 1, the sample presented with out_valid was clipped by the saturator.
- sat_count, out, CNT_W, number of clipped samples, sticks at all-ones.

Behaviour:
- Reset (rst_n low, async): amplified_output=0, out_valid=0, sat_flag=0, sat_count=0, gain register=RESET_GAIN, all pipeline valids=0, slew history=0. Reset mid-stream drops all in-flight samples.
- Gain register:
  - Updates on the clk edge where gain_load=1.
  - A sample accepted in the same cycle as gain_load uses the OLD gain.
  - The first sample using the new gain is one accepted on a later cycle.
- Stage 1, on in_valid: product = input_signal * gain, signed full precision, DATA_W+GAIN_W+1 bits. Gain is zero-extended before the multiply.
- Stage 2, scale and saturate:
  - Scaling: arithmetic shift right by FRAC_BITS (floor toward -inf; no rounding).
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; record clip bit.
- Stage 3, slew limit:
  - Let diff = target - prev, computed DATA_W+1 bits wide, where prev is the last amplified_output.
  - If slew_rate==0, or |diff| <= slew_rate: output = target.
  - Otherwise: output = prev + slew_rate when diff > 0, or prev - slew_rate when diff < 0.
  - The limited result never leaves the DATA_W range.
  - slew_rate is sampled in stage 3.
- Latency: in_valid at edge N gives out_valid=1 with the result after edge N+3. Throughput is one sample per cycle.
- Gaps in in_valid propagate as bubbles. While out_valid=0, amplified_output holds its value and prev does not change: the slew limiter advances only on valid samples.
- sat_flag: registered alongside the output. It equals the stage-2 clip bit of that sample when out_valid=1, and is 0 otherwise.
- sat_count:
  - Increments by 1 for each output sample with sat_flag=1; holds at 2^CNT_W-1.
  - sat_clr has priority: when it coincides with a clipped sample, the counter becomes 0 (the event is lost).
- Gain = 0 yields target 0. Most-negative input with maximum gain must saturate cleanly with no intermediate overflow.

Optional Feature:
- Macro: GAIN_STAGE_OFFSET_TRIM_EN.
- When defined:
  - Extra input port offset_trim (DATA_W, signed).
  - Added to the stage-2 scaled value before saturation, in DATA_W+GAIN_W+2 bits, so the trim itself can cause clipping.
  - offset_trim is sampled in stage 2.
- When undefined: the port is absent and the datapath is identical to offset 0.
- Latency is unchanged in both builds.

Test Plan:
- Reset then a stream with DATA_W=16, FRAC_BITS=8, gain 25600, slew_rate=0. Inputs 100, -50, 0 -> outputs 10000, -5000, 0, each 3 cycles after input; sat_flag=0.
- Saturation: inputs 400, -400, -32768 -> outputs 32767, -32768, -32768; sat_flag=1 for each; sat_count=3. Then sat_clr -> 0.
- Gain change: gain_load with gain_in=128 (0.5) in the same cycle as input 100, then input 100 on the next cycle -> outputs 10000 then 50. Input -3 at gain 0.5 -> -2 (floor).
- Slew: slew_rate=1000, prev 0, input 100 held valid -> outputs 1000, 2000, ..., 9000, 10000, 10000. Then input -100 -> 9000, 8000, .... With in_valid gaps, the output holds and the step count is unaffected.
- Async reset mid-stream (rst_n low for half a cycle) -> all outputs 0 immediately, no out_valid for in-flight samples, gain back to 25600.
- With GAIN_STAGE_OFFSET_TRIM_EN: offset_trim=-20000, input 100 -> -10000. offset_trim=30000, input 100 -> 32767 with sat_flag=1.

Source files
------------

// File: rtl/slew_limited_gain_stage.sv
// slew_limited_gain_stage
// The signed input sample is multiplied by a runtime-programmable unsigned
// fixed-point gain. The result is scaled by FRAC_BITS and saturated to DATA_W.
// It is then slew-rate limited against the previous valid output sample.
// Samples are valid-qualified and there is one sample per cycle. A sample
// accepted at edge N appears on the outputs after edge N+3.
// The saturator reports each clip, and a saturating counter counts them.
// Optional feature macro: GAIN_STAGE_OFFSET_TRIM_EN. It adds a signed
// offset_trim port, and that value is added before saturation.
module slew_limited_gain_stage #(
  parameter int DATA_W     = 16,
  parameter int GAIN_W     = 16,
  parameter int FRAC_BITS  = 8,
  parameter int RESET_GAIN = 25600,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] input_signal,
  input  logic                     gain_load,
  input  logic        [GAIN_W-1:0] gain_in,
  input  logic        [DATA_W-2:0] slew_rate,
  input  logic                     sat_clr,
`ifdef GAIN_STAGE_OFFSET_TRIM_EN
  input  logic signed [DATA_W-1:0] offset_trim,
`endif
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] amplified_output,
  output logic                     sat_flag,
  output logic        [CNT_W-1:0]  sat_count
);

  // Full-precision product width (gain is zero-extended, so one extra bit).
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  // Scaled value plus offset: one more bit so the sum can never wrap.
  localparam int SUM_W  = DATA_W + GAIN_W + 2;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Gain register
  logic [GAIN_W-1:0] gain_q;

  // Stage 1: product
  logic                     s1_valid_q;
  logic signed [PROD_W-1:0] s1_prod_q;
  logic signed [PROD_W-1:0] in_ext_s;
  logic signed [PROD_W-1:0] gain_ext_s;
  logic signed [PROD_W-1:0] s1_prod_d;

  // Stage 2a: scaled + offset sum
  logic                     s2_valid_q;
  logic signed [SUM_W-1:0]  s2_sum_q;
  logic signed [PROD_W-1:0] scaled_s;
  logic signed [SUM_W-1:0]  offset_ext_s;
  logic signed [SUM_W-1:0]  s2_sum_d;

  // Stage 2b: saturated target
  logic                     s3_valid_q;
  logic        [DATA_W-1:0] s3_target_q;
  logic                     s3_clip_q;
  logic        [DATA_W-1:0] s3_target_d;
  logic                     s3_clip_d;

  // Stage 3: slew limiter and outputs
  logic                     out_valid_q;
  logic        [DATA_W-1:0] out_q;
  logic                     sat_flag_q;
  logic        [CNT_W-1:0]  sat_count_q;
  logic        [DATA_W:0]   diff_s;
  logic        [DATA_W:0]   mag_s;
  logic        [DATA_W:0]   slew_ext_s;
  logic        [DATA_W-1:0] slew_step_s;
  logic        [DATA_W-1:0] out_d;

  // Gain register: a sample accepted on the load edge still sees the old gain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_q <= GAIN_W'(RESET_GAIN);
    end else if (gain_load) begin
      gain_q <= gain_in;
    end else begin
      gain_q <= gain_q;
    end
  end

  // Stage 1 combinational: signed full-precision multiply with zero-extended gain.
  always_comb begin
    in_ext_s   = {{(PROD_W-DATA_W){input_signal[DATA_W-1]}}, input_signal};
    gain_ext_s = {{(PROD_W-GAIN_W){1'b0}}, gain_q};
    s1_prod_d  = in_ext_s * gain_ext_s;
  end

  // Stage 1 register: capture the product for accepted samples only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= {PROD_W{1'b0}};
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_prod_q <= s1_prod_d;
      end else begin
        s1_prod_q <= s1_prod_q;
      end
    end
  end

  // Stage 2a combinational: floor-scale by FRAC_BITS, then add the optional trim.
  always_comb begin
    scaled_s = s1_prod_q >>> FRAC_BITS;
`ifdef GAIN_STAGE_OFFSET_TRIM_EN
    offset_ext_s = {{(SUM_W-DATA_W){offset_trim[DATA_W-1]}}, offset_trim};
`else
    offset_ext_s = {SUM_W{1'b0}};
`endif
    s2_sum_d = {{(SUM_W-PROD_W){scaled_s[PROD_W-1]}}, scaled_s} + offset_ext_s;
  end

  // Stage 2a register: hold the wide pre-saturation value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= {SUM_W{1'b0}};
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q <= s2_sum_d;
      end else begin
        s2_sum_q <= s2_sum_q;
      end
    end
  end

  // Stage 2b combinational: clamp to the DATA_W range and flag clipping.
  always_comb begin
    s3_target_d = s2_sum_q[DATA_W-1:0];
    s3_clip_d   = 1'b0;
    if (s2_sum_q > SAT_MAX) begin
      s3_target_d = SAT_MAX[DATA_W-1:0];
      s3_clip_d   = 1'b1;
    end else if (s2_sum_q < SAT_MIN) begin
      s3_target_d = SAT_MIN[DATA_W-1:0];
      s3_clip_d   = 1'b1;
    end else begin
      s3_target_d = s2_sum_q[DATA_W-1:0];
      s3_clip_d   = 1'b0;
    end
  end

  // Stage 2b register: saturated target and its clip bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q  <= 1'b0;
      s3_target_q <= {DATA_W{1'b0}};
      s3_clip_q   <= 1'b0;
    end else begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_target_q <= s3_target_d;
        s3_clip_q   <= s3_clip_d;
      end else begin
        s3_target_q <= s3_target_q;
        s3_clip_q   <= s3_clip_q;
      end
    end
  end

  // Stage 3 combinational: limit the step from the previous output to slew_rate.
  always_comb begin
    diff_s      = {s3_target_q[DATA_W-1], s3_target_q} - {out_q[DATA_W-1], out_q};
    mag_s       = diff_s[DATA_W] ? ({(DATA_W+1){1'b0}} - diff_s) : diff_s;
    slew_ext_s  = {2'b00, slew_rate};
    slew_step_s = {1'b0, slew_rate};
    out_d       = s3_target_q;
    if ((slew_rate == {(DATA_W-1){1'b0}}) || (mag_s <= slew_ext_s)) begin
      out_d = s3_target_q;
    end else if (!diff_s[DATA_W]) begin
      // The step stays between prev and target, so it cannot leave the range.
      out_d = out_q + slew_step_s;
    end else begin
      out_d = out_q - slew_step_s;
    end
  end

  // Output register: the limiter history advances only on valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= {DATA_W{1'b0}};
      sat_flag_q  <= 1'b0;
    end else begin
      out_valid_q <= s3_valid_q;
      sat_flag_q  <= s3_valid_q & s3_clip_q;
      if (s3_valid_q) begin
        out_q <= out_d;
      end else begin
        out_q <= out_q;
      end
    end
  end

  // Clip counter: sticks at all-ones; clear wins over a coincident clip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_q <= {CNT_W{1'b0}};
    end else if (sat_clr) begin
      sat_count_q <= {CNT_W{1'b0}};
    end else if (s3_valid_q && s3_clip_q && (sat_count_q != CNT_MAX)) begin
      sat_count_q <= sat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_count_q <= sat_count_q;
    end
  end

  assign out_valid        = out_valid_q;
  assign amplified_output = out_q;
  assign sat_flag         = sat_flag_q;
  assign sat_count        = sat_count_q;

endmodule

// File: tb/tb_slew_limited_gain_stage.sv
// Directed testbench for slew_limited_gain_stage (default parameters).
// Expected values are hand-computed. Offset-trim checks are included
// when GAIN_STAGE_OFFSET_TRIM_EN is defined.
module tb_slew_limited_gain_stage;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] input_signal;
  logic               gain_load;
  logic        [15:0] gain_in;
  logic        [14:0] slew_rate;
  logic               sat_clr;
`ifdef GAIN_STAGE_OFFSET_TRIM_EN
  logic signed [15:0] offset_trim;
`endif
  logic               out_valid;
  logic signed [15:0] amplified_output;
  logic               sat_flag;
  logic        [15:0] sat_count;

  int tests_run;
  int tests_failed;

  // Slew scenario: one row per clock tick.
  int sl_v  [18] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  int sl_x  [18] = '{100, 100, 100, 100, 100, 0, 0, 100, 100, 100, 100, 100, 100,
                     -100, -100, 0, 0, 0};
  int sl_ev [18] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  int sl_eo [18] = '{0, 0, 0, 1000, 2000, 3000, 4000, 5000, 5000, 5000, 6000, 7000,
                     8000, 9000, 10000, 10000, 9000, 8000};

  slew_limited_gain_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .input_signal     (input_signal),
    .gain_load        (gain_load),
    .gain_in          (gain_in),
    .slew_rate        (slew_rate),
    .sat_clr          (sat_clr),
`ifdef GAIN_STAGE_OFFSET_TRIM_EN
    .offset_trim      (offset_trim),
`endif
    .out_valid        (out_valid),
    .amplified_output (amplified_output),
    .sat_flag         (sat_flag),
    .sat_count        (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v, input int x);
    logic [31:0] xv;
    xv           = x;
    in_valid     = (v != 0);
    input_signal = xv[15:0];
    tick();
  endtask

  task automatic check_out(input string tag, input int v, input int o, input int f);
    check({tag, "_valid"}, int'(out_valid), v);
    check({tag, "_out"}, int'(amplified_output), o);
    check({tag, "_flag"}, int'(sat_flag), f);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    input_signal = 16'sd0;
    gain_load    = 1'b0;
    gain_in      = 16'd0;
    slew_rate    = 15'd0;
    sat_clr      = 1'b0;
`ifdef GAIN_STAGE_OFFSET_TRIM_EN
    offset_trim  = 16'sd0;
`endif

    // Reset state
    #12;
    check_out("reset", 0, 0, 0);
    check("reset_cnt", int'(sat_count), 0);
    rst_n = 1'b1;
    tick();

    // Basic stream, gain 100.0, limiter bypassed
    send(1, 100);
    send(1, -50);
    send(1, 0);
    send(0, 0);
    check_out("basic0", 1, 10000, 0);
    send(0, 0);
    check_out("basic1", 1, -5000, 0);
    send(0, 0);
    check_out("basic2", 1, 0, 0);
    send(0, 0);
    check_out("basic_idle", 0, 0, 0);

    // Saturation in both directions, including the most-negative input
    send(1, 400);
    send(1, -400);
    send(1, -32768);
    send(0, 0);
    check_out("sat0", 1, 32767, 1);
    check("sat0_cnt", int'(sat_count), 1);
    send(0, 0);
    check_out("sat1", 1, -32768, 1);
    check("sat1_cnt", int'(sat_count), 2);
    send(0, 0);
    check_out("sat2", 1, -32768, 1);
    check("sat2_cnt", int'(sat_count), 3);
    send(0, 0);
    check_out("sat_idle", 0, -32768, 0);
    check("sat_idle_cnt", int'(sat_count), 3);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check("sat_clr_cnt", int'(sat_count), 0);

    // Gain change: the sample on the load edge uses the old gain
    gain_load = 1'b1;
    gain_in   = 16'd128;
    send(1, 100);
    gain_load = 1'b0;
    send(1, 100);
    send(1, -3);
    send(0, 0);
    check_out("gain_old", 1, 10000, 0);
    send(0, 0);
    check_out("gain_new", 1, 50, 0);
    send(0, 0);
    check_out("gain_floor", 1, -2, 0);

    // Async reset mid-stream drops in-flight samples and restores the gain
    send(1, 100);
    send(1, 100);
    send(1, 100);
    send(0, 0);
    check_out("pre_rst", 1, 50, 0);
    rst_n = 1'b0;
    #3;
    check_out("in_rst", 0, 0, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(0, 0);
      check(     $sformatf("post_rst%0d_valid", i), int'(out_valid), 0);
      check(     $sformatf("post_rst%0d_out", i), int'(amplified_output), 0);
    end

    // Slew limiting with bubbles; first output also proves gain is back to 100.0
    slew_rate = 15'd1000;
    for (int t = 0; t < 18; t++) begin
      send(sl_v[t], sl_x[t]);
      check($sformatf("slew_t%0d_valid", t), int'(out_valid), sl_ev[t]);
      check($sformatf("slew_t%0d_out", t), int'(amplified_output), sl_eo[t]);
    end
    slew_rate = 15'd0;

    // Gain zero gives zero
    gain_load = 1'b1;
    gain_in   = 16'd0;
    send(0, 0);
    gain_load = 1'b0;
    send(1, -32768);
    send(0, 0);
    send(0, 0);
    send(0, 0);
    check_out("gain_zero", 1, 0, 0);

    // Maximum gain with extreme inputs saturates cleanly
    gain_load = 1'b1;
    gain_in   = 16'hFFFF;
    send(0, 0);
    gain_load = 1'b0;
    send(1, -32768);
    send(1, 32767);
    send(0, 0);
    send(0, 0);
    check_out("maxg_neg", 1, -32768, 1);
    check("maxg_neg_cnt", int'(sat_count), 1);
    send(0, 0);
    check_out("maxg_pos", 1, 32767, 1);
    check("maxg_pos_cnt", int'(sat_count), 2);

    // Clear coinciding with a clipped sample wins
    send(1, -32768);
    send(0, 0);
    send(0, 0);
    sat_clr = 1'b1;
    send(0, 0);
    sat_clr = 1'b0;
    check_out("clr_prio", 1, -32768, 1);
    check("clr_prio_cnt", int'(sat_count), 0);
    send(1, 32767);
    send(0, 0);
    send(0, 0);
    send(0, 0);
    check("after_clr_cnt", int'(sat_count), 1);

`ifdef GAIN_STAGE_OFFSET_TRIM_EN
    // Offset trim added before saturation
    gain_load = 1'b1;
    gain_in   = 16'd25600;
    send(0, 0);
    gain_load   = 1'b0;
    offset_trim = -16'sd20000;
    send(1, 100);
    send(0, 0);
    send(0, 0);
    send(0, 0);
    check_out("trim_neg", 1, -10000, 0);
    offset_trim = 16'sd30000;
    send(1, 100);
    send(0, 0);
    send(0, 0);
    send(0, 0);
    check_out("trim_clip", 1, 32767, 1);
    offset_trim = 16'sd0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
